// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// A radix-2 shift-add multiplier and a restoring divider share one pair of
// accumulator registers; both work on operand magnitudes and a final FIX
// state applies sign correction before the result is committed to HI/LO.
// MTHI/MTLO write HI/LO directly from IDLE without stalling the pipeline.

module muldiv_ctrl #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 6
) (
    input  logic              m_i_clk,
    input  logic              m_i_rst,
    input  logic              m_i_start,
    input  logic [2:0]        m_i_op,
    input  logic [DWIDTH-1:0] m_i_data_rs,
    input  logic [DWIDTH-1:0] m_i_data_rt,
    input  logic              m_i_flush,
    output logic              m_o_busy,
    output logic              m_o_done,
    output logic              m_o_div_zero,
    output logic [DWIDTH-1:0] m_o_hi,
    output logic [DWIDTH-1:0] m_o_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CWIDTH-1:0] ITERATIONS = CWIDTH'(DWIDTH);
    localparam logic [CWIDTH-1:0] LAST_ITER  = CWIDTH'(1);

    // Control state
    state_t              state_q, state_d;
    logic [CWIDTH-1:0]   count_q, count_d;

    // Iteration datapath: opa holds multiplicand or divisor magnitude,
    // acc_hi/acc_lo hold the running product or remainder/quotient.
    logic [DWIDTH-1:0]   opa_q, opa_d;
    logic [DWIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [DWIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [DWIDTH-1:0]   rs_raw_q, rs_raw_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                dzero_q, dzero_d;

    // Architectural registers and registered status outputs
    logic [DWIDTH-1:0]   hi_q, hi_d;
    logic [DWIDTH-1:0]   lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dz_out_q, dz_out_d;

    // Decode helpers
    logic                issue;
    logic                is_signed_op;
    logic                rs_neg;
    logic                rt_neg;
    logic [DWIDTH-1:0]   rs_mag;
    logic [DWIDTH-1:0]   rt_mag;

    // Per-iteration and fix-up arithmetic
    logic [DWIDTH:0]     mul_sum;
    logic [DWIDTH:0]     div_shift;
    logic                div_ge;
    logic [DWIDTH-1:0]   div_sub;
    logic [2*DWIDTH-1:0] prod_raw;
    logic [2*DWIDTH-1:0] prod_fix;
    logic [DWIDTH-1:0]   quo_fix;
    logic [DWIDTH-1:0]   rem_fix;

    assign m_o_busy     = busy_q;
    assign m_o_done     = done_q;
    assign m_o_div_zero = dz_out_q;
    assign m_o_hi       = hi_q;
    assign m_o_lo       = lo_q;

    // State register for the sequencer FSM
    always_ff @(posedge m_i_clk or posedge m_i_rst) begin
        if (m_i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush always wins, and a start is only taken in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (m_i_start && !m_i_flush && !m_i_op[2]) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (m_i_flush) begin
                    state_d = IDLE;
                end else if (count_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: busy follows the upcoming state, done/div_zero mark a commit
    always_comb begin
        busy_d   = (state_d == CALC) || (state_d == FIX);
        done_d   = (state_q == FIX) && !m_i_flush;
        dz_out_d = (state_q == FIX) && !m_i_flush && dzero_q;
    end

    // Operand decode: magnitudes for signed ops, raw values for unsigned ops
    always_comb begin
        issue        = (state_q == IDLE) && m_i_start && !m_i_flush;
        is_signed_op = !m_i_op[0];
        rs_neg       = is_signed_op && m_i_data_rs[DWIDTH-1];
        rt_neg       = is_signed_op && m_i_data_rt[DWIDTH-1];
        rs_mag       = rs_neg ? (~m_i_data_rs + 1'b1) : m_i_data_rs;
        rt_mag       = rt_neg ? (~m_i_data_rt + 1'b1) : m_i_data_rt;
    end

    // Iteration step and sign fix-up arithmetic for both multiply and divide
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[DWIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opa_q});
        div_sub   = div_shift[DWIDTH-1:0] - opa_q;
        prod_raw  = {acc_hi_q, acc_lo_q};
        prod_fix  = neg_res_q ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix   = neg_res_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix   = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
    end

    // Datapath next-state: latch operands on issue, iterate in CALC, commit in FIX
    always_comb begin
        count_d   = count_q;
        opa_d     = opa_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        rs_raw_d  = rs_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dzero_d   = dzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    unique case (m_i_op)
                        OP_MULT, OP_MULTU: begin
                            count_d   = ITERATIONS;
                            is_div_d  = 1'b0;
                            opa_d     = rs_mag;
                            acc_hi_d  = '0;
                            acc_lo_d  = rt_mag;
                            rs_raw_d  = m_i_data_rs;
                            neg_res_d = rs_neg ^ rt_neg;
                            neg_rem_d = 1'b0;
                            dzero_d   = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            count_d   = ITERATIONS;
                            is_div_d  = 1'b1;
                            opa_d     = rt_mag;
                            acc_hi_d  = '0;
                            acc_lo_d  = rs_mag;
                            rs_raw_d  = m_i_data_rs;
                            neg_res_d = rs_neg ^ rt_neg;
                            neg_rem_d = rs_neg;
                            dzero_d   = (m_i_data_rt == '0);
                        end
                        OP_MTHI: begin
                            hi_d = m_i_data_rs;
                        end
                        OP_MTLO: begin
                            lo_d = m_i_data_rs;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            CALC: begin
                if (!m_i_flush) begin
                    count_d = count_q - 1'b1;
                    if (is_div_q) begin
                        if (div_ge) begin
                            acc_hi_d = div_sub;
                            acc_lo_d = {acc_lo_q[DWIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_d = div_shift[DWIDTH-1:0];
                            acc_lo_d = {acc_lo_q[DWIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_d = mul_sum[DWIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[DWIDTH-1:1]};
                    end
                end
            end
            FIX: begin
                if (!m_i_flush) begin
                    if (is_div_q) begin
                        if (dzero_q) begin
                            hi_d = rs_raw_q;
                            lo_d = '1;
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end
                    end else begin
                        hi_d = prod_fix[2*DWIDTH-1:DWIDTH];
                        lo_d = prod_fix[DWIDTH-1:0];
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath, HI/LO and status flops, all cleared by the asynchronous reset
    always_ff @(posedge m_i_clk or posedge m_i_rst) begin
        if (m_i_rst) begin
            count_q   <= '0;
            opa_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            rs_raw_q  <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_out_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            opa_q     <= opa_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            rs_raw_q  <= rs_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dzero_q   <= dzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_out_q  <= dz_out_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed scenarios with literal expectations followed by a
// randomized run, all checked every cycle against a behavioural model that
// computes results with plain integer arithmetic and a latency countdown.

module tb_muldiv_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic          flush;
    logic          busy;
    logic          done;
    logic          dz;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int            m_rem  = 0;
    logic [DW-1:0] m_hi   = '0;
    logic [DW-1:0] m_lo   = '0;
    logic          m_done = 1'b0;
    logic          m_dz   = 1'b0;
    logic [DW-1:0] p_hi   = '0;
    logic [DW-1:0] p_lo   = '0;
    logic          p_dz   = 1'b0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.DWIDTH(DW), .CWIDTH(6)) dut (
        .m_i_clk      (clk),
        .m_i_rst      (rst),
        .m_i_start    (start),
        .m_i_op       (op),
        .m_i_data_rs  (rs),
        .m_i_data_rt  (rt),
        .m_i_flush    (flush),
        .m_o_busy     (busy),
        .m_o_done     (done),
        .m_o_div_zero (dz),
        .m_o_hi       (hi),
        .m_o_lo       (lo)
    );

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a one-cycle start from a falling edge; returns one cycle later
    task automatic applyStimulus(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference result as {div_zero, HI, LO} from ordinary integer arithmetic
    function automatic logic [2*DW:0] modelResult(input logic [2:0] o, input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b);
        longint        sa;
        longint        sb;
        longint        q;
        longint        r;
        logic [63:0]   p;
        logic [2*DW:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (o)
            3'd0: begin
                p   = 64'(sa * sb);
                res = {1'b0, p};
            end
            3'd1: begin
                p   = {32'b0, a} * {32'b0, b};
                res = {1'b0, p};
            end
            3'd2: begin
                if (b == 0) begin
                    res = {1'b1, a, 32'hFFFF_FFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {1'b0, r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 0) begin
                    res = {1'b1, a, 32'hFFFF_FFFF};
                end else begin
                    res = {1'b0, a % b, a / b};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [DW-1:0] randWord();
        logic [DW-1:0] w;
        case ($urandom_range(0, 7))
            0: w = 32'h0000_0000;
            1: w = 32'h0000_0001;
            2: w = 32'hFFFF_FFFF;
            3: w = 32'h8000_0000;
            4: w = 32'h7FFF_FFFF;
            5: w = 32'($urandom_range(0, 15));
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // Model: an accepted MULT/DIV commits exactly DW+1 edges later unless flushed
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
            m_dz   = 1'b0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_rem > 0) begin
                if (flush) begin
                    m_rem = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_hi   = p_hi;
                        m_lo   = p_lo;
                        m_done = 1'b1;
                        m_dz   = p_dz;
                    end
                end
            end else if (start && !flush) begin
                if (op <= 3'd3) begin
                    {p_dz, p_hi, p_lo} = modelResult(op, rs, rt);
                    m_rem = DW + 1;
                end else if (op == 3'd4) begin
                    m_hi = rs;
                end else if (op == 3'd5) begin
                    m_lo = rs;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        checkOutput("busy", {31'b0, busy}, {31'b0, (m_rem > 0)});
        checkOutput("done", {31'b0, done}, {31'b0, m_done});
        checkOutput("div_zero", {31'b0, dz}, {31'b0, m_dz});
        checkOutput("hi", hi, m_hi);
        checkOutput("lo", lo, m_lo);
    end

    initial begin
        int busy_cycles;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        rs    = '0;
        rt    = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // MULTU max * max with busy length measurement
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            busy_cycles++;
            @(negedge clk);
        end
        checkOutput("t1_busy_cycles", 32'(busy_cycles), 32'd33);
        checkOutput("t1_done", {31'b0, done}, 32'd1);
        checkOutput("t1_hi", hi, 32'hFFFF_FFFE);
        checkOutput("t1_lo", lo, 32'h0000_0001);

        // Signed multiply and divide
        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd7);
        repeat (33) @(negedge clk);
        checkOutput("t2_mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("t2_mult_lo", lo, 32'hFFFF_FFEB);
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
        repeat (33) @(negedge clk);
        checkOutput("t2_div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("t2_div_hi", hi, 32'hFFFF_FFFF);

        // Divide by zero and the signed overflow case
        applyStimulus(3'd3, 32'd100, 32'd0);
        repeat (33) @(negedge clk);
        checkOutput("t3_dz_done", {31'b0, done}, 32'd1);
        checkOutput("t3_dz_flag", {31'b0, dz}, 32'd1);
        checkOutput("t3_dz_hi", hi, 32'd100);
        checkOutput("t3_dz_lo", lo, 32'hFFFF_FFFF);
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (33) @(negedge clk);
        checkOutput("t3_ovf_lo", lo, 32'h8000_0000);
        checkOutput("t3_ovf_hi", hi, 32'h0);
        checkOutput("t3_ovf_dz", {31'b0, dz}, 32'd0);

        // MTHI then MTLO on consecutive cycles
        applyStimulus(3'd4, 32'h1234_5678, 32'h0);
        checkOutput("t4_mthi_hi", hi, 32'h1234_5678);
        checkOutput("t4_mthi_busy", {31'b0, busy}, 32'd0);
        applyStimulus(3'd5, 32'h9ABC_DEF0, 32'h0);
        checkOutput("t4_mtlo_lo", lo, 32'h9ABC_DEF0);
        checkOutput("t4_mtlo_hi", hi, 32'h1234_5678);
        checkOutput("t4_mtlo_done", {31'b0, done}, 32'd0);

        // Flush mid-CALC leaves HI/LO untouched
        applyStimulus(3'd1, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("t5_flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("t5_flush_hi", hi, 32'h1234_5678);
        checkOutput("t5_flush_lo", lo, 32'h9ABC_DEF0);
        @(negedge clk);
        checkOutput("t5_flush_done", {31'b0, done}, 32'd0);

        // Rerun with an ignored start during CALC
        applyStimulus(3'd1, 32'd5, 32'd6);
        repeat (4) @(negedge clk);
        applyStimulus(3'd1, 32'd7, 32'd7);
        repeat (28) @(negedge clk);
        checkOutput("t5_rerun_done", {31'b0, done}, 32'd1);
        checkOutput("t5_rerun_lo", lo, 32'd30);
        checkOutput("t5_rerun_hi", hi, 32'd0);

        // Back-to-back issue in the done cycle
        applyStimulus(3'd1, 32'd2, 32'd3);
        repeat (32) @(negedge clk);
        @(negedge clk);
        checkOutput("t6_first_done", {31'b0, done}, 32'd1);
        checkOutput("t6_first_lo", lo, 32'd6);
        applyStimulus(3'd3, 32'd10, 32'd3);
        checkOutput("t6_second_busy", {31'b0, busy}, 32'd1);
        repeat (33) @(negedge clk);
        checkOutput("t6_second_done", {31'b0, done}, 32'd1);
        checkOutput("t6_second_lo", lo, 32'd3);
        checkOutput("t6_second_hi", hi, 32'd1);

        // Asynchronous reset in the middle of CALC
        applyStimulus(3'd0, 32'd1234, 32'd5678);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("t6_rst_hi", hi, 32'd0);
        checkOutput("t6_rst_lo", lo, 32'd0);
        checkOutput("t6_rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized traffic including flushes, ignored starts and reserved ops
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            rs    = randWord();
            rt    = randWord();
            flush = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
